// File: rtl/pspin_her_pkg.sv
// Shared HER definitions for the PsPIN HER arbiter: default field widths,
// the packed HER bundle and a slice helper for flattened per-source arrays.
package pspin_her_pkg;

  localparam int unsigned C_MSGID_WIDTH  = 10;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned META_WIDTH     = 256;

  typedef struct packed {
    logic [C_MSGID_WIDTH-1:0]  msgid;
    logic                      is_eom;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ADDR_WIDTH-1:0] size;
    logic [AXI_ADDR_WIDTH-1:0] xfer_size;
    logic [META_WIDTH-1:0]     meta;
  } her_t;

  // Low bit of element idx inside a flattened array of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pspin_rr_arb.sv
// Generic round-robin arbiter: grants the first requester after ptr_i,
// wrapping around; returns a one-hot grant, its index and a grant-valid flag.
module pspin_rr_arb #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [NUM_SRC-1:0]   gnt_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  // Priority search starting one past the last winner.
  always_comb begin
    gnt_o = {NUM_SRC{1'b0}};
    idx_o = {IDX_WIDTH{1'b0}};
    any_o = 1'b0;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      automatic int cand = (int'(ptr_i) + k) % int'(NUM_SRC);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_WIDTH'(cand);
        any_o       = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/pspin_her_arb.sv
// Round-robin arbiter sharing the PsPIN HER port among NUM_SRC producers with
// per-source in-flight credits. Optional counters: PSPIN_HER_ARB_STATS_EN.
module pspin_her_arb
  import pspin_her_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned SRC_ID_WIDTH   = $clog2(NUM_SRC),
  parameter int unsigned C_MSGID_WIDTH  = pspin_her_pkg::C_MSGID_WIDTH,
  parameter int unsigned AXI_ADDR_WIDTH = pspin_her_pkg::AXI_ADDR_WIDTH,
  parameter int unsigned META_WIDTH     = pspin_her_pkg::META_WIDTH,
  parameter int unsigned MAX_INFLIGHT   = 8,
  parameter int unsigned CNT_WIDTH      = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*C_MSGID_WIDTH-1:0]  src_msgid,
  input  logic [NUM_SRC-1:0]                src_is_eom,
  input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] src_size,
  input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] src_xfer_size,
  input  logic [NUM_SRC*META_WIDTH-1:0]     src_meta,
  output logic                              her_valid,
  input  logic                              her_ready,
  output logic [C_MSGID_WIDTH-1:0]          her_msgid,
  output logic                              her_is_eom,
  output logic [AXI_ADDR_WIDTH-1:0]         her_addr,
  output logic [AXI_ADDR_WIDTH-1:0]         her_size,
  output logic [AXI_ADDR_WIDTH-1:0]         her_xfer_size,
  output logic [META_WIDTH-1:0]             her_meta,
  output logic [SRC_ID_WIDTH-1:0]           her_src,
  input  logic                              fb_valid,
  input  logic [SRC_ID_WIDTH-1:0]           fb_src,
  output logic [NUM_SRC*CNT_WIDTH-1:0]      inflight,
`ifdef PSPIN_HER_ARB_STATS_EN
  output logic [NUM_SRC*32-1:0]             stat_grants,
  output logic [31:0]                       stat_stall,
`endif
  output logic                              err_fb_underflow
);

  logic [NUM_SRC-1:0]        elig_s, req_s, gnt_s;
  logic [SRC_ID_WIDTH-1:0]   gidx_s, ptr_q;
  logic                      gany_s, load_s, underflow_s;
  logic [CNT_WIDTH-1:0]      cnt_q [NUM_SRC];
  logic [CNT_WIDTH-1:0]      cnt_d [NUM_SRC];

  logic                      her_valid_q, err_q;
  logic [C_MSGID_WIDTH-1:0]  msgid_q;
  logic                      eom_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, size_q, xfer_q;
  logic [META_WIDTH-1:0]     meta_q;
  logic [SRC_ID_WIDTH-1:0]   src_q;

  // Eligibility uses registered counts so same-cycle feedback cannot unblock a full source.
  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      elig_s[i] = src_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_INFLIGHT));
    end
    load_s = !her_valid_q || her_ready;
    req_s  = (load_s && rstn) ? elig_s : {NUM_SRC{1'b0}};
  end

  pspin_rr_arb #(
    .NUM_SRC   (NUM_SRC),
    .IDX_WIDTH (SRC_ID_WIDTH)
  ) u_rr_arb (
    .req_i (req_s),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gidx_s),
    .any_o (gany_s)
  );

  assign src_ready = gnt_s;

  // Credit update: a grant and a completion for the same source cancel out.
  always_comb begin
    underflow_s = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (fb_valid && (fb_src == SRC_ID_WIDTH'(i)) && (cnt_q[i] == {CNT_WIDTH{1'b0}})) begin
        underflow_s = 1'b1;
      end else begin
        underflow_s = underflow_s;
      end
      if (gnt_s[i] && !(fb_valid && (fb_src == SRC_ID_WIDTH'(i)))) begin
        cnt_d[i] = cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (!gnt_s[i] && fb_valid && (fb_src == SRC_ID_WIDTH'(i)) &&
                   (cnt_q[i] != {CNT_WIDTH{1'b0}})) begin
        cnt_d[i] = cnt_q[i] - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Credit counters and sticky underflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_SRC); i++) cnt_q[i] <= {CNT_WIDTH{1'b0}};
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) cnt_q[i] <= cnt_d[i];
      err_q <= err_q | underflow_s;
    end
  end

  // HER output stage and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      her_valid_q <= 1'b0;
      msgid_q     <= {C_MSGID_WIDTH{1'b0}};
      eom_q       <= 1'b0;
      addr_q      <= {AXI_ADDR_WIDTH{1'b0}};
      size_q      <= {AXI_ADDR_WIDTH{1'b0}};
      xfer_q      <= {AXI_ADDR_WIDTH{1'b0}};
      meta_q      <= {META_WIDTH{1'b0}};
      src_q       <= {SRC_ID_WIDTH{1'b0}};
      ptr_q       <= SRC_ID_WIDTH'(NUM_SRC - 1);
    end else if (load_s) begin
      if (gany_s) begin
        her_valid_q <= 1'b1;
        msgid_q     <= src_msgid[slice_lo(gidx_s, C_MSGID_WIDTH) +: C_MSGID_WIDTH];
        eom_q       <= src_is_eom[gidx_s];
        addr_q      <= src_addr[slice_lo(gidx_s, AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
        size_q      <= src_size[slice_lo(gidx_s, AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
        xfer_q      <= src_xfer_size[slice_lo(gidx_s, AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
        meta_q      <= src_meta[slice_lo(gidx_s, META_WIDTH) +: META_WIDTH];
        src_q       <= gidx_s;
        ptr_q       <= gidx_s;
      end else begin
        her_valid_q <= 1'b0;
      end
    end
  end

  assign her_valid        = her_valid_q;
  assign her_msgid        = msgid_q;
  assign her_is_eom       = eom_q;
  assign her_addr         = addr_q;
  assign her_size         = size_q;
  assign her_xfer_size    = xfer_q;
  assign her_meta         = meta_q;
  assign her_src          = src_q;
  assign err_fb_underflow = err_q;

  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_inflight
    assign inflight[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

`ifdef PSPIN_HER_ARB_STATS_EN
  logic [31:0] grants_q [NUM_SRC];
  logic [31:0] stall_q;

  // Free-running grant and stall counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_SRC); i++) grants_q[i] <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) grants_q[i] <= grants_q[i] + {31'd0, gnt_s[i]};
      stall_q <= stall_q + {31'd0, ((|src_valid) && !gany_s)};
    end
  end

  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_stats
    assign stat_grants[g*32 +: 32] = grants_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_pspin_her_arb.sv
// Randomized self-checking bench for pspin_her_arb with a queue-free
// behavioural model of the arbitration, credit and output-stage rules.
module tb_pspin_her_arb;

  localparam int NS   = 4;
  localparam int IW   = 2;
  localparam int MW   = 10;
  localparam int AW   = 32;
  localparam int XW   = 256;
  localparam int MAXI = 2;
  localparam int CW   = 2;

  logic              clk, rstn;
  logic [NS-1:0]     src_valid, src_ready, src_is_eom;
  logic [NS*MW-1:0]  src_msgid;
  logic [NS*AW-1:0]  src_addr, src_size, src_xfer_size;
  logic [NS*XW-1:0]  src_meta;
  logic              her_valid, her_ready, her_is_eom;
  logic [MW-1:0]     her_msgid;
  logic [AW-1:0]     her_addr, her_size, her_xfer_size;
  logic [XW-1:0]     her_meta;
  logic [IW-1:0]     her_src, fb_src;
  logic              fb_valid, err_fb_underflow;
  logic [NS*CW-1:0]  inflight;
`ifdef PSPIN_HER_ARB_STATS_EN
  logic [NS*32-1:0]  stat_grants;
  logic [31:0]       stat_stall;
`endif

  pspin_her_arb #(.NUM_SRC(NS), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rstn(rstn),
    .src_valid(src_valid), .src_ready(src_ready), .src_msgid(src_msgid),
    .src_is_eom(src_is_eom), .src_addr(src_addr), .src_size(src_size),
    .src_xfer_size(src_xfer_size), .src_meta(src_meta),
    .her_valid(her_valid), .her_ready(her_ready), .her_msgid(her_msgid),
    .her_is_eom(her_is_eom), .her_addr(her_addr), .her_size(her_size),
    .her_xfer_size(her_xfer_size), .her_meta(her_meta), .her_src(her_src),
    .fb_valid(fb_valid), .fb_src(fb_src), .inflight(inflight),
`ifdef PSPIN_HER_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_stall(stat_stall),
`endif
    .err_fb_underflow(err_fb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: what the HER port and credits must look like.
  bit          m_valid, m_eom, m_err;
  logic [MW-1:0] m_msgid;
  logic [AW-1:0] m_addr, m_size, m_xfer;
  logic [XW-1:0] m_meta;
  int          m_src, m_ptr;
  int          m_cnt [NS];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick();
    if (m_valid && !her_ready) return -1;
    for (int k = 1; k <= NS; k++) begin
      int c;
      c = (m_ptr + k) % NS;
      if (src_valid[c] && m_cnt[c] < MAXI) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_eom = 0; m_err = 0; m_msgid = '0; m_addr = '0;
    m_size = '0; m_xfer = '0; m_meta = '0; m_src = 0; m_ptr = NS - 1;
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NS; i++) begin
      src_msgid[i*MW +: MW] = MW'($urandom);
      src_is_eom[i] = 1'($urandom);
      src_addr[i*AW +: AW] = $urandom;
      src_size[i*AW +: AW] = $urandom;
      src_xfer_size[i*AW +: AW] = $urandom;
      for (int j = 0; j < XW / 32; j++) src_meta[i*XW + j*32 +: 32] = $urandom;
    end
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic cycle();
    int pick;
    logic [NS-1:0] er;
    logic [NS*CW-1:0] ei;
    #1;
    pick = model_pick();
    er = (pick >= 0) ? (4'b0001 << pick) : 4'b0000;
    chk("src_ready", src_ready, er);
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      bit inc, dec;
      inc = (pick == i);
      dec = fb_valid && (int'(fb_src) == i);
      if (dec && m_cnt[i] == 0) m_err = 1;
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (pick >= 0) begin
      m_valid = 1; m_src = pick; m_ptr = pick;
      m_msgid = src_msgid[pick*MW +: MW];
      m_eom   = src_is_eom[pick];
      m_addr  = src_addr[pick*AW +: AW];
      m_size  = src_size[pick*AW +: AW];
      m_xfer  = src_xfer_size[pick*AW +: AW];
      m_meta  = src_meta[pick*XW +: XW];
    end else if (!m_valid || her_ready) begin
      m_valid = 0;
    end
    #1;
    for (int i = 0; i < NS; i++) ei[i*CW +: CW] = CW'(m_cnt[i]);
    chk("her_valid", her_valid, m_valid);
    chk("her_src", her_src, m_src);
    chk("her_msgid", her_msgid, m_msgid);
    chk("her_is_eom", her_is_eom, m_eom);
    chk("her_addr", her_addr, m_addr);
    chk("her_size", her_size, m_size);
    chk("her_xfer_size", her_xfer_size, m_xfer);
    chk("her_meta", her_meta, m_meta);
    chk("inflight", inflight, ei);
    chk("err_fb_underflow", err_fb_underflow, m_err);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    #2;
    src_valid = 4'hF;
    fb_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_her_valid", her_valid, 1'b0);
    chk("rst_inflight", inflight, 8'h00);
    chk("rst_err", err_fb_underflow, 1'b0);
    chk("rst_her_msgid", her_msgid, 10'd0);
    chk("rst_src_ready", src_ready, 4'h0);
    src_valid = 4'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int order [8];
  int per_src [NS];
  logic [MW-1:0] saved_msgid;

  initial begin
    rstn = 1'b0; src_valid = '0; her_ready = 1'b0; fb_valid = 1'b0; fb_src = '0;
    rand_fields();
    model_reset();
    do_reset();

    // Single source
    @(negedge clk);
    rand_fields();
    src_valid = 4'b0001; src_msgid[9:0] = 10'd5; src_addr[31:0] = 32'h1000;
    src_size[31:0] = 32'd64; her_ready = 1'b1;
    cycle();
    chk("single_valid", her_valid, 1'b1);
    chk("single_src", her_src, 2'd0);
    chk("single_msgid", her_msgid, 10'd5);
    chk("single_addr", her_addr, 32'h1000);
    chk("single_size", her_size, 32'd64);
    chk("single_inflight0", inflight[CW-1:0], 2'd1);
    do_reset();

    // Fairness with all sources requesting
    for (int i = 0; i < NS; i++) per_src[i] = 0;
    her_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      rand_fields();
      src_valid = 4'hF;
      cycle();
      order[n] = int'(her_src);
      per_src[her_src]++;
    end
    for (int n = 0; n < 8; n++) chk("fair_order", order[n], n % NS);
    for (int i = 0; i < NS; i++) chk("fair_count", per_src[i], 2);
    chk("fair_inflight_full", inflight, 8'hAA);
    @(negedge clk);
    src_valid = 4'hF;
    cycle();
    chk("fair_all_full_idle", her_valid, 1'b0);
    do_reset();

    // Backpressure
    @(negedge clk);
    rand_fields(); src_valid = 4'b0010; her_ready = 1'b0;
    cycle();
    chk("bp_first_src", her_src, 2'd1);
    saved_msgid = her_msgid;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      rand_fields(); src_valid = 4'b0110; her_ready = 1'b0;
      cycle();
      chk("bp_hold_msgid", her_msgid, saved_msgid);
    end
    @(negedge clk);
    rand_fields(); src_valid = 4'b0110; her_ready = 1'b1;
    cycle();
    chk("bp_release_src", her_src, 2'd2);
    do_reset();

    // Credit limit
    her_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      rand_fields(); src_valid = 4'b0001;
      cycle();
    end
    @(negedge clk);
    src_valid = 4'b0001;
    #1 chk("credit_full_ready", src_ready, 4'b0000);
    cycle();
    @(negedge clk);
    src_valid = 4'b0001; fb_valid = 1'b1; fb_src = 2'd0;
    #1 chk("credit_fb_same_cycle", src_ready, 4'b0000);
    cycle();
    @(negedge clk);
    fb_valid = 1'b0; src_valid = 4'b0001;
    #1 chk("credit_regrant_ready", src_ready, 4'b0001);
    cycle();
    chk("credit_regrant_valid", her_valid, 1'b1);
    do_reset();

    // Simultaneous grant and feedback on source 3
    @(negedge clk);
    rand_fields(); src_valid = 4'b1000;
    cycle();
    chk("simul_pre", inflight[7:6], 2'd1);
    @(negedge clk);
    rand_fields(); src_valid = 4'b1000; fb_valid = 1'b1; fb_src = 2'd3;
    cycle();
    chk("simul_inflight3", inflight[7:6], 2'd1);
    chk("simul_src", her_src, 2'd3);

    // Underflow on an idle source
    @(negedge clk);
    src_valid = 4'b0000; fb_valid = 1'b1; fb_src = 2'd2;
    cycle();
    chk("underflow_set", err_fb_underflow, 1'b1);
    @(negedge clk);
    fb_valid = 1'b0;
    cycle();
    chk("underflow_sticky", err_fb_underflow, 1'b1);
    do_reset();

    // Random traffic with a mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rand_fields();
      src_valid = NS'($urandom);
      her_ready = ($urandom % 4) != 0;
      fb_valid = ($urandom % 3) == 0;
      fb_src = IW'($urandom);
      cycle();
      if (n == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
